// File: rtl/instr_mem_loader.sv
// Instruction memory loader: assembles a byte stream MSB-first into 32-bit words and writes them.
// Optional trailing XOR checksum byte after the HALT word is enabled by INSTR_LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int               SIZE            = 32,
    parameter int               MAX_INSTRUCTION = 64,
    parameter int               ADDR_WIDTH      = $clog2(MAX_INSTRUCTION),
    parameter logic [SIZE-1:0]  HALT_WORD       = 32'hFFFF_FFFF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_inst_write_enable,
    output logic [ADDR_WIDTH-1:0] o_write_addr,
    output logic [SIZE-1:0]       o_write_data,
    output logic                  o_stall,
    output logic                  o_rst_debug,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [ADDR_WIDTH:0]   o_word_count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAX_INSTRUCTION - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_FLUSH,
        S_DONE,
        S_ERR
`ifdef INSTR_LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [SIZE-1:0]       word_q, word_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [SIZE-1:0]       wdata_q, wdata_d;
    logic                  stall_q, stall_d;
    logic                  error_q, error_d;
    logic [SIZE-1:0]       shifted;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    assign shifted = {word_q[SIZE-9:0], i_rx_data};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            byte_idx_q <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            count_q    <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            stall_q    <= 1'b0;
            error_q    <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            stall_q    <= stall_d;
            error_q    <= error_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        addr_d     = addr_q;
        count_d    = count_q;
        we_d       = 1'b0;
        waddr_d    = '0;
        wdata_d    = '0;
        stall_d    = stall_q;
        error_d    = error_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_d    = S_LOAD;
                    byte_idx_d = '0;
                    word_d     = '0;
                    addr_d     = '0;
                    count_d    = '0;
                    error_d    = 1'b0;
                    stall_d    = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            S_LOAD: begin
                if (i_rx_valid) begin
                    word_d     = shifted;
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ i_rx_data;
`endif
                    // The strobe is loaded on the same edge that accepts the last byte.
                    if (byte_idx_q == 2'd3) begin
                        state_d = S_WRITE;
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = shifted;
                    end
                end
            end
            S_WRITE: begin
                count_d = count_q + 1'b1;
                if (addr_q != LAST_ADDR) begin
                    addr_d = addr_q + 1'b1;
                end
                if (word_q == HALT_WORD) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_FLUSH;
`endif
                end else if (addr_q == LAST_ADDR) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end else begin
                    state_d = S_LOAD;
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (i_rx_valid) begin
                    if (i_rx_data == csum_q) begin
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            S_FLUSH: begin
                state_d = S_DONE;
                stall_d = 1'b0;
            end
            S_ERR: begin
                state_d = S_DONE;
                stall_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_inst_write_enable = we_q;
    assign o_write_addr        = waddr_q;
    assign o_write_data        = wdata_q;
    assign o_stall             = stall_q;
    assign o_rst_debug         = (state_q == S_FLUSH);
    assign o_busy              = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_done              = (state_q == S_DONE);
    assign o_error             = error_q;
    assign o_word_count        = count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes are queued by the driver, a monitor checks them.
module tb_instr_mem_loader;

    localparam int AW = 6;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_start;
    logic [7:0]    i_rx_data;
    logic          i_rx_valid;
    logic          o_inst_write_enable;
    logic [AW-1:0] o_write_addr;
    logic [31:0]   o_write_data;
    logic          o_stall;
    logic          o_rst_debug;
    logic          o_busy;
    logic          o_done;
    logic          o_error;
    logic [AW:0]   o_word_count;

    int checks = 0;
    int errors = 0;
    int rstdbg_count = 0;
    logic [AW+31:0] exp_q[$];

    instr_mem_loader dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_start             (i_start),
        .i_rx_data           (i_rx_data),
        .i_rx_valid          (i_rx_valid),
        .o_inst_write_enable (o_inst_write_enable),
        .o_write_addr        (o_write_addr),
        .o_write_data        (o_write_data),
        .o_stall             (o_stall),
        .o_rst_debug         (o_rst_debug),
        .o_busy              (o_busy),
        .o_done              (o_done),
        .o_error             (o_error),
        .o_word_count        (o_word_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Monitor: pops the scoreboard on every write strobe, tracks debug-reset pulses.
    always @(negedge i_clk) begin
        logic [AW+31:0] e;
        if (i_rst_n) begin
            if (o_inst_write_enable) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%0d data=%h", o_write_addr, o_write_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_write_addr, o_write_data} !== e) begin
                        errors++;
                        $display("FAIL write got addr=%0d data=%h required addr=%0d data=%h",
                                 o_write_addr, o_write_data, e[AW+31:32], e[31:0]);
                    end else begin
                        $display("write addr=%0d data=%h ok", o_write_addr, o_write_data);
                    end
                end
            end
            if (o_rst_debug) rstdbg_count++;
            if (o_busy) begin
                checks++;
                if (!o_stall) begin
                    errors++;
                    $display("FAIL stall_while_busy got=0 required=1");
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, act, exp);
        end else begin
            $display("check %s = %h ok", name, act);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_we"},    {31'd0, o_inst_write_enable}, 32'd0);
        chk({tag, "_waddr"}, {26'd0, o_write_addr}, 32'd0);
        chk({tag, "_wdata"}, o_write_data, 32'd0);
        chk({tag, "_stall"}, {31'd0, o_stall}, 32'd0);
        chk({tag, "_rstdbg"},{31'd0, o_rst_debug}, 32'd0);
        chk({tag, "_busy"},  {31'd0, o_busy}, 32'd0);
        chk({tag, "_done"},  {31'd0, o_done}, 32'd0);
        chk({tag, "_error"}, {31'd0, o_error}, 32'd0);
        chk({tag, "_count"}, {25'd0, o_word_count}, 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clk);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic start_load();
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        chk("start_stall", {31'd0, o_stall}, 32'd1);
        chk("start_busy",  {31'd0, o_busy}, 32'd1);
        chk("start_done",  {31'd0, o_done}, 32'd0);
        chk("start_error", {31'd0, o_error}, 32'd0);
    endtask

    // Sends one word; the strobe must be up at the negedge right after the 4th byte, gone one cycle later.
    task automatic send_word(input logic [AW-1:0] a, input logic [31:0] w, input bit spurious);
        exp_q.push_back({a, w});
        for (int b = 0; b < 4; b++) begin
            @(negedge i_clk);
            i_rx_data  = w[31-8*b -: 8];
            i_rx_valid = 1'b1;
            @(negedge i_clk);
            i_rx_valid = 1'b0;
        end
        chk("strobe_on", {31'd0, o_inst_write_enable}, 32'd1);
        if (spurious) begin
            i_rx_data  = 8'hA5;
            i_rx_valid = 1'b1;
            i_start    = 1'b1;
        end
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        i_start    = 1'b0;
        chk("strobe_off", {31'd0, o_inst_write_enable}, 32'd0);
`ifndef INSTR_LOADER_CHECKSUM_EN
        if (spurious && w == 32'hFFFF_FFFF) begin
            i_rx_data  = 8'h5A;
            i_rx_valid = 1'b1;
            i_start    = 1'b1;
            @(negedge i_clk);
            i_rx_valid = 1'b0;
            i_start    = 1'b0;
        end
`endif
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (o_done) got = 1'b1;
            else @(negedge i_clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout got=0 required=1");
        end
    endtask

    initial begin
        int snap;
        i_rst_n    = 1'b0;
        i_start    = 1'b0;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        chk_idle_outputs("reset");
        i_rst_n = 1'b1;

        // Reset in the middle of a word: nothing may be written.
        snap = rstdbg_count;
        start_load();
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        chk_idle_outputs("midreset");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("midreset_no_rstdbg", rstdbg_count - snap, 32'd0);

        // Two-word program with HALT, spurious strobes during WRITE/FLUSH.
        snap = rstdbg_count;
        start_load();
        send_word(6'd0, 32'h2408_0005, 1'b1);
        send_word(6'd1, 32'hFFFF_FFFF, 1'b1);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(8'h29);
`endif
        wait_done();
        chk("prog_rstdbg", rstdbg_count - snap, 32'd1);
        chk("prog_done",   {31'd0, o_done}, 32'd1);
        chk("prog_error",  {31'd0, o_error}, 32'd0);
        chk("prog_count",  {25'd0, o_word_count}, 32'd2);
        chk("prog_stall",  {31'd0, o_stall}, 32'd0);
        chk("prog_busy",   {31'd0, o_busy}, 32'd0);

        // Overflow: 64 words with no HALT.
        snap = rstdbg_count;
        start_load();
        for (int i = 0; i < 64; i++) begin
            send_word(AW'(i), 32'h1000_0000 + i, 1'b0);
        end
        wait_done();
        chk("ovf_rstdbg", rstdbg_count - snap, 32'd0);
        chk("ovf_error",  {31'd0, o_error}, 32'd1);
        chk("ovf_done",   {31'd0, o_done}, 32'd1);
        chk("ovf_count",  {25'd0, o_word_count}, 32'd64);

        // New start from DONE clears error/done (checked in start_load), HALT-only program.
        snap = rstdbg_count;
        start_load();
        send_word(6'd0, 32'hFFFF_FFFF, 1'b0);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        wait_done();
        chk("halt_rstdbg", rstdbg_count - snap, 32'd1);
        chk("halt_error",  {31'd0, o_error}, 32'd0);
        chk("halt_count",  {25'd0, o_word_count}, 32'd1);

`ifdef INSTR_LOADER_CHECKSUM_EN
        // Bad checksum: error, no debug reset.
        snap = rstdbg_count;
        start_load();
        send_word(6'd0, 32'h2408_0005, 1'b0);
        send_word(6'd1, 32'hFFFF_FFFF, 1'b0);
        send_byte(8'h00);
        wait_done();
        chk("csum_rstdbg", rstdbg_count - snap, 32'd0);
        chk("csum_error",  {31'd0, o_error}, 32'd1);
        chk("csum_count",  {25'd0, o_word_count}, 32'd2);
`endif

        repeat (2) @(negedge i_clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
